// File: rtl/game_state_ctl_pkg.sv
// Shared encodings for the game-flow sequencer: FSM states and frame counter width.
package game_state_ctl_pkg;

    localparam int unsigned StateW    = 3;
    localparam int unsigned FrameCntW = 8;

    typedef enum logic [StateW-1:0] {
        StIdle    = 3'd0,
        StPlay    = 3'd1,
        StFreeze  = 3'd2,
        StOver    = 3'd3,
        StRestart = 3'd4
    } state_e;

    // Snake/score logic is held in reset whenever no game is on the board.
    function automatic logic holds_snake_rst(state_e st);
        return (st == StIdle) || (st == StRestart);
    endfunction

endpackage

// File: rtl/game_state_ctl_btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button plus a registered one-cycle rising-edge pulse.
module game_state_ctl_btn_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic pulse_o
);

    logic sync1_q, sync2_q, prev_q, pulse_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/game_state_ctl.sv
// Game-flow sequencer: IDLE/PLAY/FREEZE/OVER/RESTART with frame-aligned GAME OVER banner.
// Define GAME_OVER_BLINK_EN to make the banner blink while in OVER.
module game_state_ctl #(
    parameter int unsigned FREEZE_FRAMES = 60,
    parameter int unsigned HOLD_FRAMES   = 120,
    parameter int unsigned BLINK_FRAMES  = 30
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vblnk_in,
    input  logic       collision,
    input  logic       btn_start,
    output logic       game_over,
    output logic       run,
    output logic       snake_rst,
    output logic [2:0] state
);
    import game_state_ctl_pkg::*;

    localparam logic [FrameCntW-1:0] CntOne     = 1;
    localparam logic [FrameCntW-1:0] FreezeLast = FrameCntW'(FREEZE_FRAMES - 1);
    localparam logic [FrameCntW-1:0] HoldCnt    = FrameCntW'(HOLD_FRAMES);

    state_e                 state_q, state_d;
    logic [FrameCntW-1:0]   frame_cnt_q, frame_cnt_d;
    logic                   game_over_q, game_over_d;
    logic                   run_q, snake_rst_q;
    logic                   vblnk_q;
    logic                   frame_tick, btn_press;

    assign frame_tick = vblnk_in & ~vblnk_q;

    game_state_ctl_btn_sync_edge u_btn_sync (
        .clk_i   (pclk),
        .rst_i   (rst),
        .d_i     (btn_start),
        .pulse_o (btn_press)
    );

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            StIdle: begin
                if (btn_press) state_d = StRestart;
            end
            StRestart: begin
                if (frame_tick) begin
                    state_d     = StPlay;
                    frame_cnt_d = '0;
                end
            end
            StPlay: begin
                if (collision) begin
                    state_d     = StFreeze;
                    frame_cnt_d = '0;
                end
            end
            StFreeze: begin
                if (frame_tick) begin
                    if (frame_cnt_q == FreezeLast) begin
                        state_d     = StOver;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CntOne;
                    end
                end
            end
            StOver: begin
                // The press is judged against the count before this cycle's tick.
                if (btn_press && frame_cnt_q == HoldCnt) state_d = StRestart;
                if (frame_tick && frame_cnt_q != HoldCnt) frame_cnt_d = frame_cnt_q + CntOne;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef GAME_OVER_BLINK_EN
    localparam logic [FrameCntW-1:0] BlinkLast = FrameCntW'(BLINK_FRAMES - 1);

    logic [FrameCntW-1:0] blink_cnt_q, blink_cnt_d;

    always_comb begin
        game_over_d = game_over_q;
        blink_cnt_d = blink_cnt_q;
        if (frame_tick) begin
            if (state_d != StOver) begin
                game_over_d = 1'b0;
                blink_cnt_d = '0;
            end else if (state_q != StOver) begin
                game_over_d = 1'b1;
                blink_cnt_d = '0;
            end else if (blink_cnt_q == BlinkLast) begin
                game_over_d = ~game_over_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) blink_cnt_q <= '0;
        else     blink_cnt_q <= blink_cnt_d;
    end
`else
    always_comb begin
        game_over_d = game_over_q;
        if (frame_tick) game_over_d = (state_d == StOver);
    end
`endif

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            frame_cnt_q <= '0;
            game_over_q <= 1'b0;
            run_q       <= 1'b0;
            snake_rst_q <= 1'b1;
            vblnk_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            game_over_q <= game_over_d;
            run_q       <= (state_d == StPlay);
            snake_rst_q <= holds_snake_rst(state_d);
            vblnk_q     <= vblnk_in;
        end
    end

    assign game_over = game_over_q;
    assign run       = run_q;
    assign snake_rst = snake_rst_q;
    assign state     = state_q;

endmodule
